// File: rtl/lc4_seq_alu.sv
// lc4_seq_alu: handshaked ALU for the LC4 execute stage.
// Simple ops finish in one cycle. MUL (when MUL_ITER=1) and unsigned DIV/MOD
// take one bit per cycle over WIDTH cycles. A registered result is held
// until the consumer takes it, and the producer stalls on o_ready.
`timescale 1ns/1ps

module lc4_seq_alu #(
    parameter  int WIDTH    = 16,
    parameter  int MUL_ITER = 1,
    localparam int SH_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SH_W-1:0]  i_shamt,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_MOD     = 4'd4;
    localparam logic [3:0] OP_AND     = 4'd5;
    localparam logic [3:0] OP_NOT     = 4'd6;
    localparam logic [3:0] OP_OR      = 4'd7;
    localparam logic [3:0] OP_XOR     = 4'd8;
    localparam logic [3:0] OP_SLL     = 4'd9;
    localparam logic [3:0] OP_SRA     = 4'd10;
    localparam logic [3:0] OP_SRL     = 4'd11;
    localparam logic [3:0] OP_CONST   = 4'd12;
    localparam logic [3:0] OP_HICONST = 4'd13;

    // Iteration counter runs 0 .. WIDTH-1, one bit per cycle.
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]  LO_MASK  = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;

    // Shift-add multiplier state: accumulator, shifted multiplicand, multiplier.
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    // Restoring divider state: partial remainder (one guard bit), dividend/quotient, divisor.
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;

    logic               w_ready;
    logic               w_accept;
    logic               w_start_mul;
    logic               w_start_div;
    logic [WIDTH-1:0]   w_fast;
    logic signed [WIDTH-1:0] w_a_signed;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH+1:0]   w_div_sh;
    logic [WIDTH+1:0]   w_div_diff;
    logic               w_div_ok;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_div_result;

    assign w_ready     = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_ready);
    assign w_accept    = i_valid && w_ready;
    assign w_start_mul = (i_op == OP_MUL) && (MUL_ITER != 0);
    assign w_start_div = (i_op == OP_DIV) || (i_op == OP_MOD);
    assign w_a_signed  = i_a;

    // One multiply step: add the multiplicand when the current multiplier LSB is set.
    assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // One restoring-divide step: shift in the next dividend bit, try subtracting.
    // A clear top bit of the difference means no borrow, i.e. quotient bit 1.
    assign w_div_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_sh - {2'b00, r_divisor};
    assign w_div_ok    = ~w_div_diff[WIDTH+1];
    assign w_rem_next  = w_div_ok ? w_div_diff[WIDTH:0] : w_div_sh[WIDTH:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_div_ok};

    // Divide by zero reports 0 for both quotient and remainder.
    assign w_div_result = (r_divisor == '0) ? '0 :
                          ((r_op == OP_MOD) ? w_rem_next[WIDTH-1:0] : w_quo_next);

    assign o_ready  = w_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_busy   = r_busy;

    // Single-cycle result for every op that does not iterate.
    always_comb begin
        w_fast = '0;
        case (i_op)
            OP_ADD:     w_fast = i_a + i_b;
            OP_SUB:     w_fast = i_a - i_b;
            OP_MUL: begin
                if (MUL_ITER == 0) begin
                    w_fast = i_a * i_b;
                end else begin
                    w_fast = '0;
                end
            end
            OP_AND:     w_fast = i_a & i_b;
            OP_NOT:     w_fast = ~i_a;
            OP_OR:      w_fast = i_a | i_b;
            OP_XOR:     w_fast = i_a ^ i_b;
            OP_SLL:     w_fast = i_a << i_shamt;
            OP_SRA:     w_fast = w_a_signed >>> i_shamt;
            OP_SRL:     w_fast = i_a >> i_shamt;
            OP_CONST:   w_fast = i_b;
            OP_HICONST: w_fast = (i_a & LO_MASK) | (i_b << (WIDTH/2));
            default:    w_fast = '0;
        endcase
    end

    // Control FSM and datapath registers; accepting a request takes priority
    // because it can only happen from IDLE or from DONE as the result retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_result  <= '0;
            r_op      <= 4'd0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else if (w_accept) begin
            r_op  <= i_op;
            r_cnt <= '0;
            if (w_start_mul) begin
                r_acc    <= '0;
                r_mcand  <= i_a;
                r_mplier <= i_b;
                r_state  <= ST_MUL;
                r_busy   <= 1'b1;
                r_valid  <= 1'b0;
            end else if (w_start_div) begin
                r_rem     <= '0;
                r_quo     <= i_a;
                r_divisor <= i_b;
                r_state   <= ST_DIV;
                r_busy    <= 1'b1;
                r_valid   <= 1'b0;
            end else begin
                r_result <= w_fast;
                r_state  <= ST_DONE;
                r_valid  <= 1'b1;
                r_busy   <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_acc_next;
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_div_result;
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc4_seq_alu.sv
// Scoreboard bench for lc4_seq_alu (WIDTH=16, iterative MUL).
// The driver pushes the expected result when a request is accepted; the
// monitor pops and compares whenever a result retires.
`timescale 1ns/1ps

module tb_lc4_seq_alu;

    localparam int W  = 16;
    localparam int SH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [3:0]    i_op;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic [SH-1:0] i_shamt;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_result;
    logic          o_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [W-1:0] exp_q[$];
    bit rdy_rand = 1'b0;
    bit scramble = 1'b0;

    // Monitor-local history for the hold-while-stalled check.
    bit           hold_chk = 1'b0;
    logic [W-1:0] held_res;

    always #5 clk = ~clk;

    lc4_seq_alu #(.WIDTH(W), .MUL_ITER(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_shamt  (i_shamt),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    // Reference: the ALU's arithmetic meaning, computed with plain integers.
    function automatic logic [W-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [SH-1:0] sh);
        int unsigned ua;
        int unsigned ub;
        int unsigned r;
        logic signed [W-1:0] sa;
        ua = a;
        ub = b;
        sa = a;
        case (op)
            4'd0:    r = ua + ub;
            4'd1:    r = ua - ub;
            4'd2:    r = ua * ub;
            4'd3:    r = (ub == 0) ? 0 : ua / ub;
            4'd4:    r = (ub == 0) ? 0 : ua % ub;
            4'd5:    r = ua & ub;
            4'd6:    r = ~ua;
            4'd7:    r = ua | ub;
            4'd8:    r = ua ^ ub;
            4'd9:    r = ua << sh;
            4'd10:   r = 32'(unsigned'(W'(sa >>> sh)));
            4'd11:   r = ua >> sh;
            4'd12:   r = ub;
            4'd13:   r = (ua % 256) + (ub % 256) * 256;
            default: r = 0;
        endcase
        return W'(r);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; optionally randomise backpressure.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) i_ready = ($urandom_range(0, 9) < 7);
    endtask

    // Present one request and hold it until accepted; push its expected result.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SH-1:0] sh, input bit use_const, input logic [W-1:0] cexp);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_shamt = sh;
        i_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                exp_q.push_back(use_const ? cexp : ref_model(i_op, i_a, i_b, i_shamt));
                tick();
                i_valid = 1'b0;
                return;
            end
            tick();
            if (scramble) begin
                i_a = 16'($urandom);
                i_b = 16'($urandom);
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: o_ready never rose for op %0d", op);
        i_valid = 1'b0;
    endtask

    // Count cycles from acceptance until o_valid, and the busy cycles in between.
    task automatic wait_valid(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) return;
            if (o_busy === 1'b1) busy++;
            lat++;
            tick();
        end
        n_vec++;
        n_err++;
        $display("FAIL valid_timeout: o_valid never rose, got 0 expected 1");
    endtask

    task automatic run_lat(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [SH-1:0] sh,
                           input logic [W-1:0] cexp, input int exp_lat, input int exp_busy);
        int lat;
        int busy;
        issue(op, a, b, sh, 1'b1, cexp);
        wait_valid(lat, busy);
        check_int({name, "_latency"}, lat, exp_lat);
        check_int({name, "_busy_cycles"}, busy, exp_busy);
        tick();
    endtask

    // Scoreboard monitor: compare each retiring result and check stall hold.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                n_vec++;
                if (!(o_valid === 1'b1 && o_result === held_res)) begin
                    n_err++;
                    $display("FAIL hold: got valid=%b result=%h, expected valid=1 result=%h",
                             o_valid, o_result, held_res);
                end
            end
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got %h, expected no output", o_result);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    n_pop++;
                    if (o_result !== e) begin
                        n_err++;
                        $display("FAIL result: got %h, expected %h", o_result, e);
                    end
                end
            end
            hold_chk = (o_valid === 1'b1) && (i_ready === 1'b0);
            held_res = o_result;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomised stream.
    initial begin
        int p0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_op    = 4'd0;
        i_a     = '0;
        i_b     = '0;
        i_shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid",  {15'd0, o_valid}, 16'd0);
        check("reset_result", o_result, 16'd0);
        check("reset_busy",   {15'd0, o_busy}, 16'd0);
        check("reset_ready",  {15'd0, o_ready}, 16'd1);
        tick();

        i_ready = 1'b1;
        run_lat("add_ovf", 4'd0,  16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1, 0);
        run_lat("sub_neg", 4'd1,  16'h0000, 16'h0001, 4'd0,  16'hFFFF, 1, 0);
        run_lat("div",     4'd3,  16'd100,  16'd7,    4'd0,  16'd14,   17, 16);
        run_lat("mod",     4'd4,  16'd100,  16'd7,    4'd0,  16'd2,    17, 16);
        run_lat("div0",    4'd3,  16'd5,    16'd0,    4'd0,  16'd0,    17, 16);
        run_lat("mod0",    4'd4,  16'd5,    16'd0,    4'd0,  16'd0,    17, 16);
        run_lat("mul",     4'd2,  16'h0123, 16'h0100, 4'd0,  16'h2300, 17, 16);
        run_lat("sra",     4'd10, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 1, 0);
        run_lat("srl",     4'd11, 16'h8000, 16'h0000, 4'd15, 16'h0001, 1, 0);
        run_lat("sll",     4'd9,  16'h0001, 16'h0000, 4'd15, 16'h8000, 1, 0);
        run_lat("hiconst", 4'd13, 16'h12AB, 16'h0034, 4'd0,  16'h34AB, 1, 0);
        run_lat("op15",    4'd15, 16'h1234, 16'h5678, 4'd3,  16'h0000, 1, 0);

        // Backpressure: hold a DIV result, then stream ADDs behind it.
        i_ready = 1'b0;
        begin
            int lat;
            int busy;
            issue(4'd3, 16'd1000, 16'd3, 4'd0, 1'b1, 16'h014D);
            wait_valid(lat, busy);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("stall_valid",  {15'd0, o_valid}, 16'd1);
            check("stall_result", o_result, 16'h014D);
            check("stall_ready",  {15'd0, o_ready}, 16'd0);
        end
        tick();
        i_ready = 1'b1;
        p0 = n_pop;
        issue(4'd0, 16'h0001, 16'h0002, 4'd0, 1'b1, 16'h0003);
        issue(4'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 16'h0000);
        issue(4'd0, 16'h1234, 16'h4321, 4'd0, 1'b1, 16'h5555);
        issue(4'd0, 16'h8000, 16'h8000, 4'd0, 1'b1, 16'h0000);
        @(negedge clk);
        #1;
        check_int("stream_retired", n_pop - p0, 5);
        tick();

        // Reset in the middle of a divide discards it.
        issue(4'd3, 16'd100, 16'd7, 4'd0, 1'b1, 16'd14);
        repeat (8) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", {15'd0, o_valid}, 16'd0);
        check("midrst_busy",  {15'd0, o_busy}, 16'd0);
        check("midrst_ready", {15'd0, o_ready}, 16'd1);
        tick();
        run_lat("div_after_rst", 4'd3, 16'd100, 16'd7, 4'd0, 16'd14, 17, 16);

        // Randomised stream with random backpressure and scrambled stalled operands.
        rdy_rand = 1'b1;
        scramble = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 :
                 (($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom));
            issue(4'($urandom_range(0, 15)), 16'($urandom), rb, 4'($urandom), 1'b0, 16'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        rdy_rand = 1'b0;
        scramble = 1'b0;
        i_ready  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check_int("drain_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
